// File: rtl/eeprom_log_pkg.sv
// Shared definitions for the EEPROM sample logger: byte width and scheduler state encoding.
package eeprom_log_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] log_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_RUN    = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FULL   = 3'd4,
    ST_ERR    = 3'd5
  } log_state_t;

  localparam log_state_t ERR_STATE = ST_ERR;

endpackage

// File: rtl/log_sample_fifo.sv
// Small power-of-two sample FIFO; the head byte is presented combinationally.
module log_sample_fifo
  import eeprom_log_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  log_byte_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output log_byte_t head
);

  localparam int AW = $clog2(DEPTH);

  log_byte_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eeprom_log_scheduler.sv
// Decimates ADC samples into a FIFO and drains it one byte per EEPROM writer handshake.
// Define LOG_TIMEOUT_EN to build the per-write watchdog that traps into the error state.
module eeprom_log_scheduler
  import eeprom_log_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] SAMPLE_DIV = 16'd50000,
  parameter logic [8:0]  MAX_WRITES = 9'd256,
  parameter logic [19:0] TIMEOUT    = 20'd1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [BYTE_W-1:0] wr_data,
  output logic              wr_start,
  input  logic              wr_done,
  output logic              busy,
  output logic              log_full,
  output logic              overflow,
  output logic [8:0]        write_count,
  output logic              timeout_err
);

  log_state_t  state;
  log_state_t  next_state;
  logic [15:0] div_cnt;
  logic        div_term;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;

  assign div_term = (div_cnt == SAMPLE_DIV - 16'd1);
  assign push     = adc_valid && div_term && (state != ST_FULL);
  assign pop      = (state == ST_COMMIT);

  // Saturating at terminal count means the first sample after a quiet spell is always taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= SAMPLE_DIV - 16'd1;
    end else if (adc_valid && div_term) begin
      div_cnt <= '0;
    end else if (!div_term) begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  log_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(adc_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      write_count <= '0;
    end else begin
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (state == ST_COMMIT) begin
        write_count <= write_count + 9'd1;
      end
    end
  end

`ifdef LOG_TIMEOUT_EN
  logic [19:0] tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == TIMEOUT - 20'd1);

  // Budget covers the whole handshake: waiting for acceptance plus the write itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state == ST_REQ) || (state == ST_RUN)) begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) next_state = ST_REQ;
      ST_REQ:    if (!wr_done) next_state = ST_RUN;
      ST_RUN:    if (wr_done) next_state = ST_COMMIT;
      ST_COMMIT: next_state = (write_count + 9'd1 == MAX_WRITES) ? ST_FULL : ST_IDLE;
      ST_FULL:   next_state = ST_FULL;
      ERR_STATE: next_state = ERR_STATE;
      default:   next_state = ST_IDLE;
    endcase
`ifdef LOG_TIMEOUT_EN
    if (((state == ST_REQ) || (state == ST_RUN)) && tmo_hit) begin
      next_state = ERR_STATE;
    end
`endif
  end

  always_comb begin
    wr_start    = (state == ST_REQ);
    busy        = (state != ST_IDLE);
    log_full    = (state == ST_FULL);
    timeout_err = 1'b0;
`ifdef LOG_TIMEOUT_EN
    timeout_err = (state == ERR_STATE);
`endif
  end

endmodule

// File: tb/tb_eeprom_log_scheduler.sv
// Randomized scenario bench for eeprom_log_scheduler; expectations come from a sample-level model.
module tb_eeprom_log_scheduler;

  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int MAXW  = 3;
  localparam int TMO   = 100;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [7:0] adc_data  = 8'd0;
  logic       adc_valid = 1'b0;
  logic       wr_done   = 1'b1;
  logic [7:0] wr_data;
  logic       wr_start;
  logic       busy;
  logic       log_full;
  logic       overflow;
  logic [8:0] write_count;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eeprom_log_scheduler #(
    .DEPTH     (DEPTH),
    .SAMPLE_DIV(16'(DIV)),
    .MAX_WRITES(9'(MAXW)),
    .TIMEOUT   (20'(TMO))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .wr_data    (wr_data),
    .wr_start   (wr_start),
    .wr_done    (wr_done),
    .busy       (busy),
    .log_full   (log_full),
    .overflow   (overflow),
    .write_count(write_count),
    .timeout_err(timeout_err)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; adc_valid = 1'b0; wr_done = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_sample(input logic [7:0] d, input int gap);
    adc_valid = 1'b1; adc_data = d;
    tick();
    adc_valid = 1'b0; adc_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic serve_one(input int drop_dly, input int done_dly,
                           output logic [7:0] got, output bit stable, output bit found);
    found = 1'b0; stable = 1'b1; got = 8'hxx;
    for (int i = 0; i < 64 && !found; i++) begin
      if (wr_start === 1'b1) found = 1'b1;
      else tick();
    end
    if (found) begin
      got = wr_data;
      repeat (drop_dly) begin
        tick();
        if (wr_data !== got || wr_start !== 1'b1) stable = 1'b0;
      end
      wr_done = 1'b0;
      repeat (done_dly) begin
        tick();
        if (wr_data !== got || wr_start !== 1'b0) stable = 1'b0;
      end
      wr_done = 1'b1;
      tick();
      if (wr_data !== got) stable = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; adc_valid = 1'b0; wr_done = 1'b1;
    tick(); tick();
    total++; if (wr_data !== 8'd0) begin bad++; $display("[TB] FAIL reset_wr_data: got=%0h want=0", wr_data); end
    total++; if (wr_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_start: got=%0b want=0", wr_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got=%0b want=0", busy); end
    total++; if (log_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_log_full: got=%0b want=0", log_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got=%0b want=0", overflow); end
    total++; if (write_count !== 9'd0) begin bad++; $display("[TB] FAIL reset_write_count: got=%0d want=0", write_count); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout_err: got=%0b want=0", timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    logic [7:0] d, got;
    bit stable, found;
    do_reset();
    d = 8'($urandom);
    send_sample(d, 0);
    total++; if (wr_start !== 1'b0) begin bad++; $display("[TB] FAIL latency_early: got=%0b want=0", wr_start); end
    tick();
    total++; if (wr_start !== 1'b1) begin bad++; $display("[TB] FAIL latency_start: got=%0b want=1", wr_start); end
    total++; if (wr_data !== d) begin bad++; $display("[TB] FAIL latency_data: got=%0h want=%0h", wr_data, d); end
    serve_one($urandom_range(0, 4), $urandom_range(1, 8), got, stable, found);
    total++; if (got !== d || !stable) begin bad++; $display("[TB] FAIL latency_write: got=%0h stable=%0b want=%0h stable=1", got, stable, d); end
    total++; if (write_count !== 9'd1) begin bad++; $display("[TB] FAIL latency_count: got=%0d want=1", write_count); end
  endtask

  task automatic test_a5();
    logic [7:0] got;
    bit stable, found;
    do_reset();
    send_sample(8'hA5, 0);
    serve_one(3, 10, got, stable, found);
    total++; if (got !== 8'hA5 || !stable) begin bad++; $display("[TB] FAIL a5_write: got=%0h stable=%0b want=a5 stable=1", got, stable); end
    total++; if (write_count !== 9'd1) begin bad++; $display("[TB] FAIL a5_count: got=%0d want=1", write_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL a5_idle: got busy=%0b want=0", busy); end
  endtask

  task automatic test_decimation();
    logic [7:0] exp_q[$];
    logic [7:0] d, got;
    bit stable, found;
    int last, n;
    do_reset();
    last = -DIV;
    for (int c = 0; c < 12; c++) begin
      d = 8'($urandom);
      adc_valid = 1'b1; adc_data = d;
      if (c - last >= DIV) begin exp_q.push_back(d); last = c; end
      tick();
    end
    adc_valid = 1'b0;
    n = (exp_q.size() < MAXW) ? exp_q.size() : MAXW;
    for (int i = 0; i < n; i++) begin
      serve_one($urandom_range(0, 3), $urandom_range(1, 5), got, stable, found);
      total++; if (got !== exp_q[i] || !stable) begin bad++; $display("[TB] FAIL decim_byte%0d: got=%0h stable=%0b want=%0h", i, got, stable, exp_q[i]); end
    end
    total++; if (write_count !== 9'(n)) begin bad++; $display("[TB] FAIL decim_count: got=%0d want=%0d", write_count, n); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL decim_overflow: got=%0b want=0", overflow); end
  endtask

  task automatic test_random_decim();
    logic [7:0] acc[$];
    logic [7:0] d, got;
    logic exp_ovf;
    bit stable, found;
    int last, len, stored, n;
    for (int r = 0; r < 3; r++) begin
      acc.delete();
      last = -DIV;
      len = $urandom_range(10, 30);
      do_reset();
      for (int c = 0; c < len; c++) begin
        d = 8'($urandom);
        adc_data = d;
        adc_valid = ($urandom_range(0, 2) != 0);
        if (adc_valid && (c - last >= DIV)) begin acc.push_back(d); last = c; end
        tick();
      end
      adc_valid = 1'b0;
      exp_ovf = (acc.size() > DEPTH);
      stored = (acc.size() < DEPTH) ? acc.size() : DEPTH;
      n = (stored < MAXW) ? stored : MAXW;
      total++; if (overflow !== exp_ovf) begin bad++; $display("[TB] FAIL rnd%0d_overflow: got=%0b want=%0b", r, overflow, exp_ovf); end
      for (int i = 0; i < n; i++) begin
        serve_one($urandom_range(0, 3), $urandom_range(1, 5), got, stable, found);
        total++; if (got !== acc[i] || !stable) begin bad++; $display("[TB] FAIL rnd%0d_byte%0d: got=%0h stable=%0b want=%0h", r, i, got, stable, acc[i]); end
      end
      total++; if (write_count !== 9'(n)) begin bad++; $display("[TB] FAIL rnd%0d_count: got=%0d want=%0d", r, write_count, n); end
      total++; if (log_full !== (n == MAXW)) begin bad++; $display("[TB] FAIL rnd%0d_full: got=%0b want=%0b", r, log_full, (n == MAXW)); end
      if (stored > MAXW) begin
        total++; if (wr_data !== acc[MAXW]) begin bad++; $display("[TB] FAIL rnd%0d_head: got=%0h want=%0h", r, wr_data, acc[MAXW]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d[6];
    logic [7:0] got;
    bit stable, found;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d[i] = 8'($urandom);
      send_sample(d[i], DIV + $urandom_range(0, 2));
      if (i == DEPTH - 1) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early: got=%0b want=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got=%0b want=1", overflow); end
    for (int i = 0; i < MAXW; i++) begin
      serve_one($urandom_range(0, 3), $urandom_range(1, 6), got, stable, found);
      total++; if (got !== d[i] || !stable) begin bad++; $display("[TB] FAIL ovf_byte%0d: got=%0h stable=%0b want=%0h", i, got, stable, d[i]); end
    end
    total++; if (wr_data !== d[MAXW]) begin bad++; $display("[TB] FAIL ovf_head: got=%0h want=%0h", wr_data, d[MAXW]); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d[4];
    logic [7:0] got, x;
    bit stable, found;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      send_sample(d[i], DIV);
    end
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      if (wr_start === 1'b1) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL pp_start: got=0 want=1"); end
    wr_done = 1'b0;
    tick(); tick();
    wr_done = 1'b1;
    tick();
    total++; if (wr_data !== d[0]) begin bad++; $display("[TB] FAIL pp_commit_head: got=%0h want=%0h", wr_data, d[0]); end
    x = 8'($urandom);
    adc_valid = 1'b1; adc_data = x;
    tick();
    adc_valid = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL pp_overflow: got=%0b want=0", overflow); end
    total++; if (write_count !== 9'd1) begin bad++; $display("[TB] FAIL pp_count: got=%0d want=1", write_count); end
    for (int i = 1; i < MAXW; i++) begin
      serve_one($urandom_range(0, 2), $urandom_range(1, 4), got, stable, found);
      total++; if (got !== d[i] || !stable) begin bad++; $display("[TB] FAIL pp_byte%0d: got=%0h stable=%0b want=%0h", i, got, stable, d[i]); end
    end
    total++; if (wr_data !== d[MAXW]) begin bad++; $display("[TB] FAIL pp_head: got=%0h want=%0h", wr_data, d[MAXW]); end
  endtask

  task automatic test_full();
    logic [7:0] d, got;
    bit stable, found;
    int starts;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_sample(d, DIV);
      if (i < MAXW) begin
        serve_one($urandom_range(0, 3), $urandom_range(1, 5), got, stable, found);
        total++; if (got !== d || !stable) begin bad++; $display("[TB] FAIL full_byte%0d: got=%0h stable=%0b want=%0h", i, got, stable, d); end
        if (i == MAXW - 2) begin
          total++; if (log_full !== 1'b0) begin bad++; $display("[TB] FAIL full_early: got=%0b want=0", log_full); end
        end
      end else begin
        starts = 0;
        repeat (8) begin
          tick();
          if (wr_start !== 1'b0) starts++;
        end
        total++; if (starts != 0) begin bad++; $display("[TB] FAIL full_start%0d: got=%0d cycles want=0", i, starts); end
      end
    end
    total++; if (write_count !== 9'(MAXW)) begin bad++; $display("[TB] FAIL full_count: got=%0d want=%0d", write_count, MAXW); end
    total++; if (log_full !== 1'b1) begin bad++; $display("[TB] FAIL full_flag: got=%0b want=1", log_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL full_overflow: got=%0b want=0", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, got;
    bit stable, found;
    do_reset();
    d = 8'($urandom);
    send_sample(d, 0);
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      if (wr_start === 1'b1) found = 1'b1;
      else tick();
    end
    wr_done = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b1 || wr_start !== 1'b0) begin bad++; $display("[TB] FAIL mid_run: got busy=%0b start=%0b want busy=1 start=0", busy, wr_start); end
    rst = 1'b1;
    tick();
    total++; if ({wr_data, wr_start, busy, log_full, overflow, write_count, timeout_err} !== 22'd0)
      begin bad++; $display("[TB] FAIL mid_reset_outputs: got data=%0h start=%0b busy=%0b full=%0b ovf=%0b cnt=%0d terr=%0b want all 0",
        wr_data, wr_start, busy, log_full, overflow, write_count, timeout_err); end
    rst = 1'b0; wr_done = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_empty: got busy=%0b want=0", busy); end
    d = 8'($urandom);
    send_sample(d, 0);
    serve_one($urandom_range(0, 3), $urandom_range(1, 6), got, stable, found);
    total++; if (got !== d || !stable) begin bad++; $display("[TB] FAIL mid_rewrite: got=%0h stable=%0b want=%0h", got, stable, d); end
    total++; if (write_count !== 9'd1) begin bad++; $display("[TB] FAIL mid_count: got=%0d want=1", write_count); end
  endtask

  task automatic test_timeout();
    bit found;
    do_reset();
    send_sample(8'($urandom), 0);
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      if (wr_start === 1'b1) found = 1'b1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL tmo_start: got=0 want=1"); end
`ifdef LOG_TIMEOUT_EN
    repeat (TMO - 1) tick();
    total++; if (timeout_err !== 1'b0 || wr_start !== 1'b1) begin bad++; $display("[TB] FAIL tmo_early: got terr=%0b start=%0b want terr=0 start=1", timeout_err, wr_start); end
    tick();
    total++; if (timeout_err !== 1'b1 || wr_start !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL tmo_err: got terr=%0b start=%0b busy=%0b want 1 0 1", timeout_err, wr_start, busy); end
    repeat (5) tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL tmo_sticky: got=%0b want=1", timeout_err); end
    do_reset();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_clear: got=%0b want=0", timeout_err); end
`else
    repeat (TMO + 50) tick();
    total++; if (timeout_err !== 1'b0 || wr_start !== 1'b1) begin bad++; $display("[TB] FAIL tmo_absent: got terr=%0b start=%0b want terr=0 start=1", timeout_err, wr_start); end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_a5();
    test_decimation();
    test_random_decim();
    test_overflow();
    test_push_pop_full();
    test_full();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
